// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Multi-cycle signed multiply/divide engine that sits directly below the
//   control unit. It takes one operation per start strobe. MUL uses radix-2
//   Booth recoding, one step per cycle. DIV uses restoring division on operand
//   magnitudes, one step per cycle, and then applies the signs (the quotient
//   truncates toward zero). The 2*WIDTH result goes to Zhi/Zlo, which feed the
//   Zhiout/Zloout bus drivers.
//
// Ports
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-low reset
//   start        in   1      operation request, sampled only in IDLE
//   MUL          in   1      select multiply (exactly one of MUL/DIV must be set)
//   DIV          in   1      select divide
//   A            in   WIDTH  multiplicand / dividend (signed)
//   B            in   WIDTH  multiplier / divisor (signed)
//   Zhi          out  WIDTH  MUL: product high half; DIV: remainder
//   Zlo          out  WIDTH  MUL: product low half;  DIV: quotient
//   busy         out  1      high in every state except IDLE
//   done         out  1      one-cycle pulse, result valid
//   div_by_zero  out  1      set with done for DIV by 0, held until next accept
//
// Timing: the accept edge is E0. WIDTH iteration edges follow, then one
// finalize edge loads Zhi/Zlo and enters DONE. done is therefore high in the
// cycle after edge E(WIDTH+1). A divide by zero skips the iterations and
// reaches DONE after edge E2.
// -----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             MUL,
  input  logic             DIV,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Zhi,
  output logic [WIDTH-1:0] Zlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // The operands are latched at accept. Later changes on the input pins are
  // ignored until the unit is back in IDLE.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  // r_p_hi has one guard bit. Booth's +/-A on the most negative A would
  // otherwise overflow the high half and corrupt the arithmetic shift.
  // In DIV mode r_p_hi holds the partial remainder and r_p_lo the quotient.
  logic [WIDTH:0]   r_p_hi;
  logic [WIDTH-1:0] r_p_lo;
  logic             r_q_m1;
  logic [WIDTH-1:0] r_zhi;
  logic [WIDTH-1:0] r_zlo;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic             w_div_zero;
  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_rem_diff;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_accept   = (r_state == S_IDLE) && start && (MUL ^ DIV);
  assign w_last     = (r_cnt == '0);
  assign w_div_zero = (r_b == '0);

  // Booth step: recode {P_lo[0], q_-1} into +A, -A or no change.
  assign w_a_ext = {r_a[WIDTH-1], r_a};

  always_comb begin
    // NOTE: default first, so no path leaves w_booth_sum unassigned (no latch).
    w_booth_sum = r_p_hi;
    case ({r_p_lo[0], r_q_m1})
      2'b01:   w_booth_sum = r_p_hi + w_a_ext;
      2'b10:   w_booth_sum = r_p_hi - w_a_ext;
      default: w_booth_sum = r_p_hi;
    endcase
  end

  // Restoring step on magnitudes. The unsigned negation of the most negative
  // value gives 2^(WIDTH-1), which is the correct magnitude. The remainder is
  // always below |B| <= 2^(WIDTH-1), so the top bit of the difference is a
  // reliable borrow flag.
  assign w_b_mag    = r_b[WIDTH-1] ? (~r_b + 1'b1) : r_b;
  assign w_rem_sh   = {r_p_hi[WIDTH-1:0], r_p_lo[WIDTH-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, w_b_mag};

  // Sign fix-up: quotient sign = sign(A) ^ sign(B); remainder follows A.
  assign w_quot_fix = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? (~r_p_lo + 1'b1) : r_p_lo;
  assign w_rem_fix  = r_a[WIDTH-1] ? (~r_p_hi[WIDTH-1:0] + 1'b1)
                                   : r_p_hi[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: non-blocking assignment for every register, so all flops see
      // pre-edge values regardless of block order.
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = MUL ? S_MUL_RUN : S_DIV_RUN;
      end
      S_MUL_RUN, S_DIV_RUN: begin
        if (w_last) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: every datapath register is reset, so a mid-operation reset
      // leaves no stale operand or partial result behind.
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_p_hi <= '0;
      r_p_lo <= '0;
      r_q_m1 <= 1'b0;
      r_zhi  <= '0;
      r_zlo  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a    <= A;
            r_b    <= B;
            r_cnt  <= CNT_W'(WIDTH);
            r_dbz  <= 1'b0;
            r_q_m1 <= 1'b0;
            r_p_hi <= '0;
            // MUL starts from {0, B, 0}. DIV starts from {0, |A|}, and
            // |A| is derived from the A input seen at this edge.
            r_p_lo <= MUL ? B : (A[WIDTH-1] ? (~A + 1'b1) : A);
          end
        end
        S_MUL_RUN: begin
          if (w_last) begin
            r_zhi <= r_p_hi[WIDTH-1:0];
            r_zlo <= r_p_lo;
          end else begin
            // Arithmetic right shift of {P_hi, P_lo, q_-1}.
            r_p_hi <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
            r_p_lo <= {w_booth_sum[0], r_p_lo[WIDTH-1:1]};
            r_q_m1 <= r_p_lo[0];
            r_cnt  <= r_cnt - 1'b1;
          end
        end
        S_DIV_RUN: begin
          if (w_last) begin
            if (w_div_zero) begin
              r_zlo <= '1;
              r_zhi <= r_a;
              r_dbz <= 1'b1;
            end else begin
              r_zlo <= w_quot_fix;
              r_zhi <= w_rem_fix;
            end
          end else if (w_div_zero) begin
            // Divisor is zero: skip the iterations and finalize on the next edge.
            r_cnt <= '0;
          end else begin
            if (!w_rem_diff[WIDTH]) begin
              r_p_hi <= {1'b0, w_rem_diff[WIDTH-1:0]};
              r_p_lo <= {r_p_lo[WIDTH-2:0], 1'b1};
            end else begin
              r_p_hi <= {1'b0, w_rem_sh[WIDTH-1:0]};
              r_p_lo <= {r_p_lo[WIDTH-2:0], 1'b0};
            end
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign Zhi         = r_zhi;
  assign Zlo         = r_zlo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//   Scoreboard bench for mul_div_unit. The driver computes each expected
//   result with plain 64-bit arithmetic and queues it when it issues the
//   operation. An independent monitor pops an entry on every done pulse and
//   compares the result, the flags and the latency from the accept edge.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         MUL;
  logic         DIV;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Zhi;
  logic [W-1:0] Zlo;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  mul_div_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .MUL         (MUL),
    .DIV         (DIV),
    .A           (A),
    .B           (B),
    .Zhi         (Zhi),
    .Zlo         (Zlo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: plain signed arithmetic, truncating division.
  function automatic exp_t model(input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, p, ma, mb, q, r;
    logic [63:0] pv, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dbz = 1'b0;
    e.lat = 33;
    e.acc_cyc = 0;
    if (is_mul) begin
      p = sa * sb;
      pv = p;
      e.hi = pv[63:32];
      e.lo = pv[31:0];
    end else if (b == '0) begin
      e.hi  = a;
      e.lo  = '1;
      e.dbz = 1'b1;
      e.lat = 2;
    end else begin
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      q  = ma / mb;
      r  = ma % mb;
      if ((sa < 0) != (sb < 0)) q = -q;
      if (sa < 0) r = -r;
      qv = q;
      rv = r;
      e.lo = qv[31:0];
      e.hi = rv[31:0];
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("zhi", 64'(Zhi), 64'(e.hi));
          check("zlo", 64'(Zlo), 64'(e.lo));
          check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          check("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
          check("busy_with_done", 64'(busy), 64'd1);
        end
      end
    end
  end

  // Issue one operation from a negedge. Optionally fire a disturbing start
  // (DIV select, new operands) disturb_at cycles after accept.
  task automatic issue(input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int disturb_at);
    exp_t e;
    int   n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      check("idle_timeout", 64'(busy), 64'd0);
      return;
    end
    e = model(is_mul, a, b);
    e.acc_cyc = cyc + 1;
    exp_q.push_back(e);
    start = 1'b1;
    MUL   = is_mul;
    DIV   = !is_mul;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    if (disturb_at > 0) begin
      repeat (disturb_at - 1) @(negedge clk);
      start = 1'b1;
      MUL   = 1'b0;
      DIV   = 1'b1;
      A     = $urandom;
      B     = $urandom;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($signed($urandom_range(0, 40)) - 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    MUL   = 1'b0;
    DIV   = 1'b0;
    A     = '0;
    B     = '0;
    #1;
    check("rst_zhi", 64'(Zhi), 64'd0);
    check("rst_zlo", 64'(Zlo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // An illegal select is ignored.
    start = 1'b1; MUL = 1'b1; DIV = 1'b1;
    @(negedge clk);
    check("ignore_both_sel", 64'(busy), 64'd0);
    MUL = 1'b0; DIV = 1'b0;
    @(negedge clk);
    check("ignore_no_sel", 64'(busy), 64'd0);
    start = 1'b0;

    // Directed corner cases.
    issue(1'b1, 32'd7, 32'hFFFF_FFFD, 0);
    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 0);
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue(1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(1'b0, 32'd5, 32'd0, 0);
    wait_drain();
    check("dbz_held", 64'(div_by_zero), 64'd1);
    @(negedge clk);
    check("dbz_held_idle", 64'(div_by_zero), 64'd1);
    issue(1'b1, 32'd3, 32'd4, 10);  // start during the run is ignored
    check("dbz_cleared_on_accept", 64'(div_by_zero), 64'd0);
    wait_drain();

    // Randomized back-to-back traffic.
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), pick(), pick(), 0);
    end
    wait_drain();

    // Reset in the middle of a divide.
    issue(1'b0, 32'd1000, 32'd3, 0);
    repeat (14) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_zhi", 64'(Zhi), 64'd0);
    check("midrst_zlo", 64'(Zlo), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", 64'(done), 64'd0);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    check("after_rst_no_done", 64'(done), 64'd0);
    issue(1'b0, 32'd100, 32'd7, 0);
    wait_drain();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
